// File: rtl/alu_ctrl.sv
// Instruction controller that drives an external combinational ALU and holds
// R0..R3. Optional macro ALU_CTRL_OVERLAP_EN lets a new instruction be accepted during the result handoff.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_zero,
    output logic        res_carry
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        is_ldi;
    logic [1:0]  rd_q;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_data;
    logic [7:0]  regs_q [4];
    logic [7:0]  alu_a_q, alu_b_q;
    logic [2:0]  alu_op_q;
    logic [7:0]  res_data_q;
    logic        res_zero_q, res_carry_q;

    assign is_ldi = instr[15];
    assign accept = instr_valid && instr_ready;

    // Output decode; instr_ready is held low while rst is asserted.
    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            IDLE: instr_ready = !rst;
            RESP: begin
                res_valid = 1'b1;
`ifdef ALU_CTRL_OVERLAP_EN
                instr_ready = res_ready && !rst;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_ldi ? RESP : EXEC;
            EXEC: state_d = RESP;
            RESP: if (res_ready) state_d = accept ? (is_ldi ? RESP : EXEC) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single write port: ALU writeback in EXEC, or immediate load on accept.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rd_q;
        wr_data = alu_result;
        if (state_q == EXEC) begin
            wr_en = 1'b1;
        end else if (accept && is_ldi) begin
            wr_en   = 1'b1;
            wr_idx  = instr[14:13];
            wr_data = instr[7:0];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (rst)
                    regs_q[gi] <= 8'h00;
                else if (wr_en && wr_idx == 2'(gi))
                    regs_q[gi] <= wr_data;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_q        <= 2'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= 3'd0;
            res_data_q  <= 8'h00;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_ldi) begin
                alu_a_q  <= regs_q[instr[9:8]];
                alu_b_q  <= regs_q[instr[7:6]];
                alu_op_q <= instr[14:12];
                rd_q     <= instr[11:10];
            end
            if (state_q == EXEC) begin
                res_data_q  <= alu_result;
                res_zero_q  <= alu_zero;
                res_carry_q <= alu_carry;
            end else if (accept && is_ldi) begin
                res_data_q  <= instr[7:0];
                res_zero_q  <= (instr[7:0] == 8'h00);
                res_carry_q <= 1'b0;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign res_carry  = res_carry_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed plus randomized bench for alu_ctrl with an environment ALU and a
// register-file reference model.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        alu_zero, alu_carry;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
    logic        res_zero, res_carry;

    int passed = 0;
    int total  = 0;

    logic [7:0] m [4];
    logic [7:0] last_a, last_b;
    logic [2:0] last_op;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry)
    );

    // Returns {carry, result}; carry is the borrow for sub/dec.
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, r;
        ai = a; bi = b;
        case (op)
            3'd0: begin r = ai + bi; return {r > 255, 8'(r)}; end
            3'd1: return {ai < bi, 8'(ai - bi)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {ai == 255, 8'(ai + 1)};
            3'd6: return {ai == 0, 8'(ai - 1)};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb begin
        logic [8:0] rr;
        rr = alu_fn(alu_opcode, alu_a, alu_b);
        alu_result = rr[7:0];
        alu_carry  = rr[8];
        alu_zero   = (rr[7:0] == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {1'b1, rd, 5'b0, imm};
    endfunction

    function automatic logic [15:0] alu_i(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 6'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_op = 3'd0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
    task automatic issue(input string tag, input logic [15:0] w, input int stall);
        logic [7:0] ed;
        logic       ec;
        logic [8:0] rr;
        int         lat, lat_exp;
        if (w[15]) begin
            ed = w[7:0]; ec = 1'b0; lat_exp = 1;
            m[w[14:13]] = w[7:0];
        end else begin
            last_a = m[w[9:8]]; last_b = m[w[7:6]]; last_op = w[14:12];
            rr = alu_fn(last_op, last_a, last_b);
            ed = rr[7:0]; ec = rr[8]; lat_exp = 2;
            m[w[11:10]] = ed;
        end
        instr = w; instr_valid = 1'b1;
        chk({tag, ".ready"}, instr_ready, 1);
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; instr = 16'($urandom);
        lat = 1;
        while (!res_valid && lat < 8) begin @(negedge clk); lat++; end
        chk({tag, ".latency"}, lat, lat_exp);
        chk({tag, ".data"}, res_data, ed);
        chk({tag, ".zero"}, res_zero, ed == 8'h00);
        chk({tag, ".carry"}, res_carry, ec);
        chk({tag, ".alu_a"}, alu_a, last_a);
        chk({tag, ".alu_b"}, alu_b, last_b);
        chk({tag, ".alu_op"}, alu_opcode, last_op);
        chk({tag, ".busy"}, instr_ready, 0);
        for (int s = 0; s < stall; s++) begin
            instr_valid = 1'b1;
            @(negedge clk);
            chk({tag, ".stall_valid"}, res_valid, 1);
            chk({tag, ".stall_data"}, res_data, ed);
            chk({tag, ".stall_ready"}, instr_ready, 0);
        end
        instr_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        chk({tag, ".done"}, res_valid, 0);
        $display("txn %s instr=%04h data=%02h", tag, w, res_data);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.instr_ready", instr_ready, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.res_data", res_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.instr_ready", instr_ready, 1);

        issue("ldi_r1_05", ldi(2'd1, 8'h05), 0);
        issue("ldi_r2_03", ldi(2'd2, 8'h03), 0);

        issue("ldi_r1_ff", ldi(2'd1, 8'hFF), 0);
        issue("ldi_r2_01", ldi(2'd2, 8'h01), 0);
        issue("add_r3", alu_i(3'd0, 2'd3, 2'd1, 2'd2), 0);
        issue("pass_r3", alu_i(3'd7, 2'd0, 2'd3, 2'd0), 0);

        issue("ldi_r0_00", ldi(2'd0, 8'h00), 0);
        issue("ldi_r1_01", ldi(2'd1, 8'h01), 0);
        issue("sub_r0", alu_i(3'd1, 2'd0, 2'd0, 2'd1), 0);

        issue("stall5", ldi(2'd2, 8'hA5), 5);

        // Reset while an ADD is in EXEC.
        instr = alu_i(3'd0, 2'd3, 2'd1, 2'd2); instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        chk("exec.res_valid", res_valid, 0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("exec_rst.res_valid", res_valid, 0);
        chk("exec_rst.instr_ready", instr_ready, 0);
        chk("exec_rst.alu_a", alu_a, 0);
        chk("exec_rst.alu_b", alu_b, 0);
        chk("exec_rst.alu_op", alu_opcode, 0);
        chk("exec_rst.res_data", res_data, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        issue("pass_r0", alu_i(3'd7, 2'd0, 2'd0, 2'd0), 0);
        issue("pass_r1", alu_i(3'd7, 2'd0, 2'd1, 2'd0), 0);
        issue("pass_r3z", alu_i(3'd7, 2'd0, 2'd3, 2'd0), 0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] w;
            w = 16'($urandom);
            issue($sformatf("rnd%0d", t), w, int'($urandom_range(0, 2)));
        end

`ifdef ALU_CTRL_OVERLAP_EN
        // LDI R0,0x10 then ADD R1=R0+R0 accepted during the LDI's RESP.
        res_ready = 1'b1;
        instr = ldi(2'd0, 8'h10); instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ovl.v1", res_valid, 1);
        chk("ovl.d1", res_data, 8'h10);
        chk("ovl.ready", instr_ready, 1);
        instr = alu_i(3'd0, 2'd1, 2'd0, 2'd0);
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        chk("ovl.v2", res_valid, 0);
        @(negedge clk);
        chk("ovl.v3", res_valid, 1);
        chk("ovl.d3", res_data, 8'h20);
        @(negedge clk);
        res_ready = 1'b0;
        chk("ovl.idle", res_valid, 0);
        $display("txn overlap ldi+add data=20");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
